// File: rtl/float_dot_pkg.sv
// Shared constants and FSM state type for the half-precision dot-product feeder.
package float_dot_pkg;

    localparam int REG_SIZE = 16;
    localparam int EXP_SIZE = 5;
    localparam int FRA_SIZE = 10;
    localparam int BIAS     = 15;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/float_dot_feeder_if.sv
// Operand-pair valid/ready link between the feeder and the dot-product accumulator.
interface float_dot_feeder_if #(
    parameter int W = 16
);
    logic [W-1:0] dataOut1_44;
    logic [W-1:0] dataOut2_44;
    logic         valid_44;
    logic         ready_44;

    modport master (
        output dataOut1_44,
        output dataOut2_44,
        output valid_44,
        input  ready_44
    );

    modport slave (
        input  dataOut1_44,
        input  dataOut2_44,
        input  valid_44,
        output ready_44
    );
endinterface

// File: rtl/float_vec_bank.sv
// Dual register bank (A/B): one write port, one combinational paired read port.
module float_vec_bank #(
    parameter int W  = float_dot_pkg::REG_SIZE,
    parameter int N  = float_dot_pkg::DEPTH,
    parameter int AW = float_dot_pkg::ADDR_W
) (
    input  logic          clk_44,
    input  logic          reset_44,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_a,
    output logic [W-1:0]  rd_b
);
    logic [W-1:0] bank_a [N];
    logic [W-1:0] bank_b [N];

    always_ff @(posedge clk_44 or negedge reset_44) begin
        if (!reset_44) begin
            for (int i = 0; i < N; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_sel) bank_b[wr_addr] <= wr_data;
            else        bank_a[wr_addr] <= wr_data;
        end
    end

    assign rd_a = bank_a[rd_addr];
    assign rd_b = bank_b[rd_addr];
endmodule

// File: rtl/float_dot_feeder.sv
// Streams (A[i], B[i]) pairs from the banks to the accumulator over valid/ready.
module float_dot_feeder #(
    parameter int REG_SIZE   = float_dot_pkg::REG_SIZE,
    parameter int DEPTH      = float_dot_pkg::DEPTH,
    parameter int ADDR_W     = float_dot_pkg::ADDR_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk_44,
    input  logic                reset_44,
    input  logic                wr_en_44,
    input  logic                wr_sel_44,
    input  logic [ADDR_W-1:0]   wr_addr_44,
    input  logic [REG_SIZE-1:0] wr_data_44,
    input  logic [ADDR_W:0]     len_44,
    input  logic                start_44,
    output logic                busy_44,
    output logic                done_44,
    float_dot_feeder_if.master  pair
);
    import float_dot_pkg::*;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state, state_d;
    logic [ADDR_W:0]     idx, idx_nx, len_q, len_eff;
    logic [GW-1:0]       gap_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [REG_SIZE-1:0] rd_a, rd_b;
    logic                load, xfer, last, idle_start;

    assign len_eff    = (len_44 > DEPTH_L) ? DEPTH_L : len_44;
    assign idx_nx     = idx + 1'b1;
    assign last       = (idx_nx == len_q);
    assign xfer       = (state == PRESENT) && pair.ready_44;
    assign idle_start = (state == IDLE) && start_44;

    assign pair.valid_44 = (state == PRESENT);
    assign busy_44       = (state != IDLE);
    assign done_44       = (state == DONE);

    // Address of the pair that the next load captures.
    always_comb begin
        rd_addr = idx[ADDR_W-1:0];
        unique case (state)
            IDLE:    rd_addr = '0;
            PRESENT: rd_addr = idx_nx[ADDR_W-1:0];
            default: rd_addr = idx[ADDR_W-1:0];
        endcase
    end

    float_vec_bank #(
        .W  (REG_SIZE),
        .N  (DEPTH),
        .AW (ADDR_W)
    ) u_bank (
        .clk_44   (clk_44),
        .reset_44 (reset_44),
        .wr_en    (wr_en_44 && (state == IDLE)),
        .wr_sel   (wr_sel_44),
        .wr_addr  (wr_addr_44),
        .wr_data  (wr_data_44),
        .rd_addr  (rd_addr),
        .rd_a     (rd_a),
        .rd_b     (rd_b)
    );

    always_ff @(posedge clk_44 or negedge reset_44) begin
        if (!reset_44) state <= IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_44) begin
                    if (len_eff == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = PRESENT;
                        load    = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (pair.ready_44) begin
                    if (last)                state_d = DONE;
                    else if (GAP_CYCLES > 0) state_d = GAP;
                    else                     load    = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = PRESENT;
                    load    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_44 or negedge reset_44) begin
        if (!reset_44) begin
            idx              <= '0;
            len_q            <= '0;
            gap_cnt          <= '0;
            pair.dataOut1_44 <= '0;
            pair.dataOut2_44 <= '0;
        end else begin
            if (idle_start) begin
                len_q <= len_eff;
                idx   <= '0;
            end else if (xfer) begin
                idx <= idx_nx;
            end
            if (xfer && !last && (GAP_CYCLES > 0)) begin
                gap_cnt <= GW'(GAP_CYCLES - 1);
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (load) begin
                pair.dataOut1_44 <= rd_a;
                pair.dataOut2_44 <= rd_b;
            end
        end
    end
endmodule

// File: tb/tb_float_dot_feeder.sv
// Scoreboard bench: expected pairs queued by stimulus, popped by a handshake monitor.
module tb_float_dot_feeder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  len = '0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        ready = 1'b0;
    logic        busy0, done0, busy1, done1;

    int n_checks = 0;
    int n_fail = 0;
    int n_done0 = 0;
    int n_done1 = 0;
    int exp_done0 = 0;
    int exp_done1 = 0;
    pair_t q0[$];
    pair_t q1[$];
    pair_t e0, e1;

    float_dot_feeder_if #(.W(16)) p0 ();
    float_dot_feeder_if #(.W(16)) p1 ();

    assign p0.ready_44 = ready;
    assign p1.ready_44 = ready;

    float_dot_feeder #(.GAP_CYCLES(0)) u0 (
        .clk_44     (clk),
        .reset_44   (rst_n),
        .wr_en_44   (wr_en),
        .wr_sel_44  (wr_sel),
        .wr_addr_44 (wr_addr),
        .wr_data_44 (wr_data),
        .len_44     (len),
        .start_44   (start0),
        .busy_44    (busy0),
        .done_44    (done0),
        .pair       (p0.master)
    );

    float_dot_feeder #(.GAP_CYCLES(4)) u1 (
        .clk_44     (clk),
        .reset_44   (rst_n),
        .wr_en_44   (wr_en),
        .wr_sel_44  (wr_sel),
        .wr_addr_44 (wr_addr),
        .wr_data_44 (wr_data),
        .len_44     (len),
        .start_44   (start1),
        .busy_44    (busy1),
        .done_44    (done1),
        .pair       (p1.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (p0.valid_44 && p0.ready_44) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL pair0: unexpected transfer %h %h",
                             p0.dataOut1_44, p0.dataOut2_44);
                end else begin
                    e0 = q0.pop_front();
                    if (p0.dataOut1_44 !== e0.a || p0.dataOut2_44 !== e0.b) begin
                        n_fail++;
                        $display("FAIL pair0: got %h %h expected %h %h",
                                 p0.dataOut1_44, p0.dataOut2_44, e0.a, e0.b);
                    end
                end
            end
            if (p1.valid_44 && p1.ready_44) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL pair1: unexpected transfer %h %h",
                             p1.dataOut1_44, p1.dataOut2_44);
                end else begin
                    e1 = q1.pop_front();
                    if (p1.dataOut1_44 !== e1.a || p1.dataOut2_44 !== e1.b) begin
                        n_fail++;
                        $display("FAIL pair1: got %h %h expected %h %h",
                                 p1.dataOut1_44, p1.dataOut2_44, e1.a, e1.b);
                    end
                end
            end
            if (done0) n_done0++;
            if (done1) n_done1++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [2:0] addr,
                      input logic [15:0] data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic push0(input logic [15:0] a, input logic [15:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        q0.push_back(p);
    endtask

    task automatic push_basic0(input int n);
        logic [15:0] va [3];
        logic [15:0] vb [3];
        va = '{16'h2E66, 16'h3266, 16'h3400};
        vb = '{16'h3452, 16'hBB9A, 16'h3000};
        for (int i = 0; i < n; i++) push0(va[i], vb[i]);
    endtask

    task automatic go0(input logic [3:0] l);
        len = l;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    initial begin
        pair_t p;
        step();
        step();
        check("rst_valid", {31'd0, p0.valid_44}, 32'd0);
        check("rst_data1", {16'd0, p0.dataOut1_44}, 32'd0);
        check("rst_data2", {16'd0, p0.dataOut2_44}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        rst_n = 1'b1;
        step();

        wr(1'b0, 3'd0, 16'h2E66);
        wr(1'b0, 3'd1, 16'h3266);
        wr(1'b0, 3'd2, 16'h3400);
        wr(1'b1, 3'd0, 16'h3452);
        wr(1'b1, 3'd1, 16'hBB9A);
        wr(1'b1, 3'd2, 16'h3000);

        // basic stream
        push_basic0(3);
        ready = 1'b1;
        go0(4'd3);
        exp_done0++;
        for (int c = 1; c <= 5; c++) begin
            check("basic_valid", {31'd0, p0.valid_44}, {31'd0, c <= 3});
            check("basic_done", {31'd0, done0}, {31'd0, c == 4});
            check("basic_busy", {31'd0, busy0}, {31'd0, c <= 4});
            step();
        end

        // backpressure: ready low for cycles 1-3
        push_basic0(3);
        ready = 1'b0;
        go0(4'd3);
        exp_done0++;
        for (int c = 1; c <= 8; c++) begin
            ready = (c >= 4);
            if (c <= 4) begin
                check("bp_valid", {31'd0, p0.valid_44}, 32'd1);
                check("bp_hold1", {16'd0, p0.dataOut1_44}, 32'h2E66);
                check("bp_hold2", {16'd0, p0.dataOut2_44}, 32'h3452);
            end
            check("bp_done", {31'd0, done0}, {31'd0, c == 7});
            step();
        end

        // gap of 4 on the second instance
        p.a = 16'h2E66; p.b = 16'h3452; q1.push_back(p);
        p.a = 16'h3266; p.b = 16'hBB9A; q1.push_back(p);
        len = 4'd2;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        exp_done1++;
        for (int c = 1; c <= 8; c++) begin
            check("gap_valid", {31'd0, p1.valid_44}, {31'd0, c == 1 || c == 6});
            check("gap_done", {31'd0, done1}, {31'd0, c == 7});
            check("gap_busy", {31'd0, busy1}, {31'd0, c <= 7});
            step();
        end

        // len 0: no valid, done in cycle 1, last pair kept
        go0(4'd0);
        exp_done0++;
        check("len0_done", {31'd0, done0}, 32'd1);
        check("len0_valid", {31'd0, p0.valid_44}, 32'd0);
        check("len0_keep", {16'd0, p0.dataOut1_44}, 32'h3400);
        step();
        check("len0_busy", {31'd0, busy0}, 32'd0);

        // write and second start mid-stream are ignored
        push_basic0(3);
        go0(4'd3);
        exp_done0++;
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF;
        start0 = 1'b1;
        step();
        wr_en = 1'b0;
        start0 = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            check("ill_done", {31'd0, done0}, {31'd0, c == 4});
            step();
        end
        check("ill_done_cnt", n_done0, exp_done0);

        // start with same-cycle write: element 0 is the old value
        push_basic0(2);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 16'h1234;
        go0(4'd2);
        wr_en = 1'b0;
        exp_done0++;
        repeat (4) step();
        push0(16'h1234, 16'h3452);
        go0(4'd1);
        exp_done0++;
        repeat (3) step();

        // len 12 clamps to 8
        for (int i = 0; i < 8; i++) begin
            wr(1'b0, 3'(i), 16'h1000 + 16'(i));
            wr(1'b1, 3'(i), 16'h2000 + 16'(i));
            push0(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        go0(4'd12);
        exp_done0++;
        for (int c = 1; c <= 10; c++) begin
            check("l12_valid", {31'd0, p0.valid_44}, {31'd0, c <= 8});
            check("l12_done", {31'd0, done0}, {31'd0, c == 9});
            step();
        end

        // reset during element 1
        push0(16'h1000, 16'h2000);
        go0(4'd3);
        step();
        check("rst_mid_valid", {31'd0, p0.valid_44}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_v0", {31'd0, p0.valid_44}, 32'd0);
        check("rst_mid_d1", {16'd0, p0.dataOut1_44}, 32'd0);
        check("rst_mid_d2", {16'd0, p0.dataOut2_44}, 32'd0);
        check("rst_mid_busy", {31'd0, busy0}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_no_done", n_done0, exp_done0);
        push0(16'h0000, 16'h0000);
        push0(16'h0000, 16'h0000);
        go0(4'd2);
        exp_done0++;
        repeat (5) step();

        check("q0_empty", q0.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);
        check("done0_cnt", n_done0, exp_done0);
        check("done1_cnt", n_done1, exp_done1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
